// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// md_pkg : shared encodings for the iterative multiply/divide unit
// Rev 1.0
// ============================================================================
package md_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/md_if.sv
`default_nettype none
// ============================================================================
// md_if : operand/handshake/HI-LO bundle between control path and md_unit
// Rev 1.0
// ============================================================================
interface md_if #(
    parameter int WIDTH = md_pkg::DEF_WIDTH
);
    logic             START;
    logic [1:0]       OP;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             WR_HI;
    logic             WR_LO;
    logic [WIDTH-1:0] WDATA;
    logic             BUSY;
    logic             DONE;
    logic             DIV_BY_ZERO;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output START, OP, A, B, WR_HI, WR_LO, WDATA,
        input  BUSY, DONE, DIV_BY_ZERO, HI, LO
    );

    modport slave (
        input  START, OP, A, B, WR_HI, WR_LO, WDATA,
        output BUSY, DONE, DIV_BY_ZERO, HI, LO
    );
endinterface
`default_nettype wire

// File: rtl/md_negate.sv
`default_nettype none
// ============================================================================
// md_negate : conditional two's-complement negate
// Rev 1.0
// ============================================================================
module md_negate #(
    parameter int W = 32
) (
    input  wire logic         i_en,
    input  wire logic [W-1:0] i_val,
    output logic      [W-1:0] o_val
);
    assign o_val = i_en ? (~i_val + {{(W-1){1'b0}}, 1'b1}) : i_val;
endmodule
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// md_unit : iterative MULT/MULTU/DIV/DIVU with HI/LO result registers
// Rev 1.0
// ============================================================================
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  wire logic CLK,
    input  wire logic RST_N,
    md_if.slave       bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    state_t             r_state, w_state_nxt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b, r_hi, r_lo;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div, r_neg_q, r_neg_r, r_dbz;

    logic               w_open, w_accept, w_signed, w_dbz;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quo_fix, w_rem_fix;
    logic [2*WIDTH-1:0] w_prod_fix, w_mul_next, w_div_next;
    logic [WIDTH:0]     w_msum, w_rem_sh, w_diff;

    assign w_open   = (r_state == S_IDLE) || (r_state == S_FIN);
    assign w_accept = bus.START && w_open;
    assign w_signed = ~bus.OP[0];
    assign w_dbz    = bus.OP[1] && (bus.B == '0);

    md_negate #(.W(WIDTH)) u_neg_a (.i_en(w_signed & bus.A[WIDTH-1]), .i_val(bus.A), .o_val(w_abs_a));
    md_negate #(.W(WIDTH)) u_neg_b (.i_en(w_signed & bus.B[WIDTH-1]), .i_val(bus.B), .o_val(w_abs_b));
    md_negate #(.W(2*WIDTH)) u_neg_p (.i_en(r_neg_q), .i_val(r_acc), .o_val(w_prod_fix));
    md_negate #(.W(WIDTH)) u_neg_q (.i_en(r_neg_q), .i_val(r_acc[WIDTH-1:0]), .o_val(w_quo_fix));
    md_negate #(.W(WIDTH)) u_neg_r (.i_en(r_neg_r), .i_val(r_acc[2*WIDTH-1:WIDTH]), .o_val(w_rem_fix));

    // Multiply: accumulator is {partial product, remaining multiplier bits}
    assign w_msum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_next = {w_msum, r_acc[WIDTH-1:1]};

    // Divide: accumulator is {remainder, dividend shifting into quotient}
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff     = w_rem_sh - {1'b0, r_b};
    assign w_div_next = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                      : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_FIN: begin
                if (w_accept) w_state_nxt = w_dbz ? S_FIN : S_CALC;
                else          w_state_nxt = S_IDLE;
            end
            S_CALC:  if (r_cnt == C_LAST) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_FIN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_acc    <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dbz    <= 1'b0;
        end else if (w_accept) begin
            r_is_div <= bus.OP[1];
            r_acc    <= {{WIDTH{1'b0}}, w_abs_a};
            r_b      <= w_abs_b;
            r_neg_q  <= w_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            r_neg_r  <= w_signed & bus.A[WIDTH-1];
            r_cnt    <= '0;
            r_dbz    <= w_dbz;
            if (w_dbz) begin
                r_hi <= bus.A;
                r_lo <= '1;
            end
        end else if (w_open) begin
            if (bus.WR_HI) r_hi <= bus.WDATA;
            if (bus.WR_LO) r_lo <= bus.WDATA;
        end else if (r_state == S_CALC) begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
            r_cnt <= r_cnt + 1'b1;
        end else if (r_state == S_FIX) begin
            if (r_is_div) begin
                r_hi <= w_rem_fix;
                r_lo <= w_quo_fix;
            end else begin
                {r_hi, r_lo} <= w_prod_fix;
            end
        end
    end

    assign bus.BUSY        = (r_state == S_CALC) || (r_state == S_FIX);
    assign bus.DONE        = (r_state == S_FIN);
    assign bus.DIV_BY_ZERO = r_dbz;
    assign bus.HI          = r_hi;
    assign bus.LO          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// tb_md_unit : directed self-checking bench for md_unit
// Rev 1.0
// ============================================================================
module tb_md_unit;
    import md_pkg::*;

    logic CLK   = 1'b0;
    logic RST_N = 1'b1;

    md_if #(.WIDTH(32)) bus();

    md_unit #(.WIDTH(32)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where DONE is seen (or after reset is asserted)
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit inject, input int rst_at,
                         output int n_done, output int n_busy);
        n_done    = -1;
        n_busy    = 0;
        bus.START = 1'b1;
        bus.OP    = op;
        bus.A     = a;
        bus.B     = b;
        @(negedge CLK);
        bus.START = 1'b0;
        bus.A     = 32'h5A5A_A5A5;
        bus.B     = 32'h0000_0003;
        for (int n = 0; n < 100; n++) begin
            if (n == rst_at) begin
                RST_N = 1'b0;
                #1;
                return;
            end
            if (bus.DONE) begin
                n_done = n;
                break;
            end
            if (bus.BUSY) n_busy++;
            if (inject && n == 5) begin
                bus.START = 1'b1;
                bus.OP    = OP_MULT;
                bus.A     = 32'd9;
                bus.B     = 32'd9;
                bus.WR_HI = 1'b1;
                bus.WDATA = 32'h0000_AAAA;
            end
            if (inject && n == 6) begin
                bus.START = 1'b0;
                bus.WR_HI = 1'b0;
            end
            @(negedge CLK);
        end
    endtask

    initial begin
        int nd, nb;
        bus.START = 1'b0;
        bus.OP    = OP_MULT;
        bus.A     = '0;
        bus.B     = '0;
        bus.WR_HI = 1'b0;
        bus.WR_LO = 1'b0;
        bus.WDATA = '0;

        #2 RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        check_val("rst_hi",   bus.HI, 64'h0);
        check_val("rst_lo",   bus.LO, 64'h0);
        check_val("rst_busy", bus.BUSY, 64'h0);
        check_val("rst_done", bus.DONE, 64'h0);
        check_val("rst_dbz",  bus.DIV_BY_ZERO, 64'h0);
        RST_N = 1'b1;
        @(negedge CLK);

        bus.WR_HI = 1'b1; bus.WDATA = 32'h11;
        @(negedge CLK);
        bus.WR_HI = 1'b0; bus.WR_LO = 1'b1; bus.WDATA = 32'h22;
        @(negedge CLK);
        bus.WR_LO = 1'b0;
        check_val("mthi", bus.HI, 64'h11);
        check_val("mtlo", bus.LO, 64'h22);

        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, nd, nb);
        check_val("multu_lat",  nd, 64'd33);
        check_val("multu_busy", nb, 64'd33);
        check_val("multu_hi",   bus.HI, 64'hFFFF_FFFE);
        check_val("multu_lo",   bus.LO, 64'h0000_0001);

        do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, -1, nd, nb);
        check_val("b2b_lat",  nd, 64'd33);
        check_val("b2b_busy", nb, 64'd33);
        check_val("mult_hi",  bus.HI, 64'hFFFF_FFFF);
        check_val("mult_lo",  bus.LO, 64'hFFFF_FFEB);
        @(negedge CLK);
        check_val("done_fall", bus.DONE, 64'h0);
        check_val("idle_busy", bus.BUSY, 64'h0);

        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, -1, nd, nb);
        check_val("div_lat", nd, 64'd33);
        check_val("div_lo",  bus.LO, 64'hFFFF_FFFD);
        check_val("div_hi",  bus.HI, 64'hFFFF_FFFF);
        @(negedge CLK);

        do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, -1, nd, nb);
        check_val("div2_lo", bus.LO, 64'hFFFF_FFFD);
        check_val("div2_hi", bus.HI, 64'h0000_0001);
        @(negedge CLK);

        do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, -1, nd, nb);
        check_val("minsq_hi", bus.HI, 64'h4000_0000);
        check_val("minsq_lo", bus.LO, 64'h0000_0000);
        @(negedge CLK);

        do_op(OP_DIVU, 32'h1234, 32'h0, 1'b0, -1, nd, nb);
        check_val("dbz_lat",  nd, 64'd0);
        check_val("dbz_flag", bus.DIV_BY_ZERO, 64'h1);
        check_val("dbz_hi",   bus.HI, 64'h1234);
        check_val("dbz_lo",   bus.LO, 64'hFFFF_FFFF);
        @(negedge CLK);
        check_val("dbz_busy", bus.BUSY, 64'h0);
        check_val("dbz_done", bus.DONE, 64'h0);
        bus.WR_LO = 1'b1; bus.WDATA = 32'h55;
        @(negedge CLK);
        bus.WR_LO = 1'b0;
        check_val("mtlo_keep_dbz", bus.DIV_BY_ZERO, 64'h1);
        check_val("mtlo_dbz_lo",   bus.LO, 64'h55);

        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, nd, nb);
        check_val("ovf_lat", nd, 64'd33);
        check_val("ovf_lo",  bus.LO, 64'h8000_0000);
        check_val("ovf_hi",  bus.HI, 64'h0);
        check_val("ovf_dbz", bus.DIV_BY_ZERO, 64'h0);
        @(negedge CLK);

        do_op(OP_MULTU, 32'd5, 32'd6, 1'b1, -1, nd, nb);
        check_val("ign_lat", nd, 64'd33);
        check_val("ign_lo",  bus.LO, 64'd30);
        check_val("ign_hi",  bus.HI, 64'h0);
        @(negedge CLK);
        check_val("ign_noq", bus.BUSY, 64'h0);

        do_op(OP_MULTU, 32'd5, 32'd6, 1'b0, 10, nd, nb);
        check_val("mid_rst_hi",   bus.HI, 64'h0);
        check_val("mid_rst_lo",   bus.LO, 64'h0);
        check_val("mid_rst_busy", bus.BUSY, 64'h0);
        check_val("mid_rst_done", bus.DONE, 64'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        do_op(OP_DIVU, 32'd100, 32'd7, 1'b0, -1, nd, nb);
        check_val("post_lat", nd, 64'd33);
        check_val("post_lo",  bus.LO, 64'd14);
        check_val("post_hi",  bus.HI, 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/md_unit.md
# md_unit

Iterative multiply/divide unit with HI/LO result registers. It sits directly downstream of the register bank and takes its two read-data outputs (DR1, DR2) as operands for MULT/MULTU/DIV/DIVU. A start/busy/done handshake lets the control path stall while an operation runs. HI/LO are read back through the MFHI/MFLO path and written directly through MTHI/MTLO.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- START  input  1  request an operation; sampled only when the unit is not BUSY
- OP  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- A  input  WIDTH  operand A / dividend, from DR1
- B  input  WIDTH  operand B / divisor, from DR2
- WR_HI  input  1  MTHI write strobe
- WR_LO  input  1  MTLO write strobe
- WDATA  input  WIDTH  MTHI/MTLO data
- BUSY  output  1  operation in progress
- DONE  output  1  one-cycle pulse; HI/LO hold the new result
- DIV_BY_ZERO  output  1  last accepted DIV/DIVU had B == 0
- HI  output  WIDTH  product high word / remainder
- LO  output  WIDTH  product low word / quotient

## Operation
- States:
  - IDLE: BUSY=0, DONE=0.
  - CALC: BUSY=1, DONE=0.
  - FIX: BUSY=1, DONE=0.
  - FIN: BUSY=0, DONE=1.
- Reset is asynchronous and applies at any time, including mid-operation:
  - state goes to IDLE; HI=LO=0; BUSY=DONE=DIV_BY_ZERO=0; iteration counter=0.
  - No partial result is ever written.
- Accepting a START (IDLE or FIN):
  - Latch OP.
  - Latch |A| and |B| for signed ops; raw values for unsigned ops.
  - Latch result signs.
  - Clear counter and DIV_BY_ZERO.
  - Go to CALC.
- Divide by zero is handled when START is accepted:
  - DIV/DIVU with B == 0 sets DIV_BY_ZERO=1.
  - It writes HI=A and LO=0xFFFFFFFF on the same edge, then goes to FIN. CALC and FIX are skipped.
- CALC runs 32 iterations, one per clock:
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring shift-subtract producing a 32-bit quotient and remainder.
  - The counter runs 0..31; CALC→FIX when it reaches 31.
- FIX:
  - Signed multiply: negate the 64-bit product if sign(A) xor sign(B).
  - Signed divide: quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
  - Write HI/LO, then go to FIN.
- INT_MIN / -1 (signed) produces LO=0x80000000, HI=0. No trap.
- FIN lasts one cycle. Next state is CALC if START is accepted, otherwise IDLE.
- START while BUSY is ignored and not queued.
- WR_HI/WR_LO:
  - Take effect on the clock edge only in IDLE or FIN, and only when START is not accepted that cycle (START wins).
  - Ignored while BUSY.
  - Do not change DIV_BY_ZERO.
- HI/LO keep their previous values until FIX (or the divide-by-zero edge) writes them.
- A and B need only be valid in the START cycle; later changes have no effect.

## Timing
- START is accepted at edge k.
- BUSY is high from edge k to edge k+33.
- CALC iterations run at edges k+1..k+32.
- At edge k+33:
  - FIX writes HI/LO;
  - DONE rises;
  - BUSY falls.
- DONE falls at edge k+34 unless the cycle is a back-to-back START.
- Latency is 33 cycles from START sample to DONE high.
- Divide by zero: at edge k, HI/LO are written and DONE rises; BUSY never goes high.
- Back-to-back: a START accepted in FIN (edge k+34) makes BUSY high again at that edge.
- All outputs are registered; there are no combinational input→output paths.

## Structure
- Package `md_pkg` holds:
  - OP encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - state encoding;
  - the WIDTH default.
- One sub-module, `md_negate`: combinational, parameterised-width conditional two's-complement negate. It is used for the operand absolute values and for the FIX correction.
- The CALC datapath, counter and FSM live in `md_unit`.

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; DONE exactly 33 cycles after START; BUSY high for 33 cycles.
- MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000, DIV_BY_ZERO=0.
- DIVU A=0x1234, B=0 -> DIV_BY_ZERO=1, HI=0x1234, LO=0xFFFFFFFF, DONE on the edge after START, BUSY stays 0.
- MULTU 5×6 started; START pulse and WR_HI=0xAAAA during BUSY -> both ignored; DONE gives LO=30. Second run with reset asserted at iteration 10 -> HI=LO=0, BUSY=DONE=0. A fresh START afterwards completes correctly.
